dff_pipe: RTL and testbench

DFF_PIPE -- requirements
Module: dff_pipe

---
 rtl/dff_pipe.sv | 56 +++++
 tb/tb_dff_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_pipe.sv
// Elastic register pipeline: DEPTH valid/ready stages that collapse bubbles,
// with synchronous flush and an asynchronous active-low reset.
module dff_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]            v_q, v_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            rdy;
  logic                        in_hs;

  // A stage may advance when any stage at or beyond it is empty, or the output drains.
  for (genvar i = 0; i < DEPTH; i++) begin : g_rdy
    assign rdy[i] = out_ready | ~(&v_q[DEPTH-1:i]);
  end

  assign in_ready  = rdy[0] & ~flush & rst;
  assign in_hs     = in_valid & in_ready;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign count     = CW'($countones(v_q));

  assign v_d[0]    = flush ? 1'b0 : (rdy[0] ? in_hs : v_q[0]);
  assign data_d[0] = rdy[0] ? in_data : data_q[0];

  for (genvar i = 1; i < DEPTH; i++) begin : g_stage
    assign v_d[i]    = flush ? 1'b0 : (rdy[i] ? v_q[i-1] : v_q[i]);
    assign data_d[i] = rdy[i] ? data_q[i-1] : data_q[i];
  end

  // NOTE: data registers are reset as well, so out_data reads 0 while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q    <= '0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: three instances (8x4, 1x1, 16x7) checked every cycle
// against a slot-list model of the pipe.
module tb_dff_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_iv, a_ir, a_ov, a_or, a_fl;
  logic [7:0] a_id, a_od;
  logic [2:0] a_cnt;
  logic       b_iv, b_ir, b_ov, b_or, b_fl;
  logic [0:0] b_id, b_od;
  logic [0:0] b_cnt;
  logic        c_iv, c_ir, c_ov, c_or, c_fl;
  logic [15:0] c_id, c_od;
  logic [2:0]  c_cnt;

  dff_pipe #(.WIDTH(8), .DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .flush(a_fl), .count(a_cnt));
  dff_pipe #(.WIDTH(1), .DEPTH(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .flush(b_fl), .count(b_cnt));
  dff_pipe #(.WIDTH(16), .DEPTH(7)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
    .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .flush(c_fl), .count(c_cnt));

  int total = 0;
  int bad   = 0;
  int dep[3] = '{4, 1, 7};
  int wid[3] = '{8, 1, 16};
  // slot[u][i] holds the word in position i (0 = input side), -1 when empty
  int slot[3][8];

  logic o_ir, o_ov;
  int   o_od, o_cnt;

  task automatic model_clear();
    for (int u = 0; u < 3; u++)
      for (int i = 0; i < 8; i++) slot[u][i] = -1;
  endtask

  task automatic set_in(int u, bit iv, int d, bit ordy, bit fl);
    a_iv = 1'b0; a_id = '0; a_or = 1'b0; a_fl = 1'b0;
    b_iv = 1'b0; b_id = '0; b_or = 1'b0; b_fl = 1'b0;
    c_iv = 1'b0; c_id = '0; c_or = 1'b0; c_fl = 1'b0;
    case (u)
      0: begin a_iv = iv; a_id = d[7:0];  a_or = ordy; a_fl = fl; end
      1: begin b_iv = iv; b_id = d[0:0];  b_or = ordy; b_fl = fl; end
      default: begin c_iv = iv; c_id = d[15:0]; c_or = ordy; c_fl = fl; end
    endcase
  endtask

  task automatic sample(int u);
    case (u)
      0: begin o_ir = a_ir; o_ov = a_ov; o_od = int'(a_od); o_cnt = int'(a_cnt); end
      1: begin o_ir = b_ir; o_ov = b_ov; o_od = int'(b_od); o_cnt = int'(b_cnt); end
      default: begin o_ir = c_ir; o_ov = c_ov; o_od = int'(c_od); o_cnt = int'(c_cnt); end
    endcase
  endtask

  // One clock cycle on instance u: drive, check outputs against the model, clock, advance model.
  task automatic step(int u, string tag, bit iv, int d, bit ordy, bit fl);
    int  n, k, dm;
    bit  e_ov, e_ir, popped, acc;
    n = dep[u];
    dm = d & ((1 << wid[u]) - 1);
    set_in(u, iv, d, ordy, fl);
    #1;
    sample(u);
    k = 0;
    for (int i = 0; i < n; i++) if (slot[u][i] >= 0) k++;
    e_ov = (slot[u][n-1] >= 0);
    e_ir = ((k < n) || ordy) && !fl;
    total++;
    if (o_ir !== e_ir) begin
      bad++; $display("FAIL %s[u%0d]: in_ready got %b want %b at %0t", tag, u, o_ir, e_ir, $time);
    end
    total++;
    if (o_ov !== e_ov) begin
      bad++; $display("FAIL %s[u%0d]: out_valid got %b want %b at %0t", tag, u, o_ov, e_ov, $time);
    end
    total++;
    if (o_cnt !== k) begin
      bad++; $display("FAIL %s[u%0d]: count got %0d want %0d at %0t", tag, u, o_cnt, k, $time);
    end
    if (e_ov) begin
      total++;
      if (o_od !== slot[u][n-1]) begin
        bad++; $display("FAIL %s[u%0d]: out_data got %h want %h at %0t", tag, u, o_od, slot[u][n-1], $time);
      end
    end
    @(posedge clk);
    popped = e_ov && ordy;
    acc    = iv && e_ir;
    if (fl) begin
      for (int i = 0; i < n; i++) slot[u][i] = -1;
    end else begin
      if (popped) slot[u][n-1] = -1;
      k = -1;
      for (int i = n - 1; i >= 0; i--) if (slot[u][i] < 0) begin k = i; break; end
      if (k >= 0) begin
        for (int i = k; i > 0; i--) slot[u][i] = slot[u][i-1];
        slot[u][0] = acc ? dm : -1;
      end
    end
    @(negedge clk);
  endtask

  task automatic check_all_reset(string tag);
    for (int u = 0; u < 3; u++) begin
      sample(u);
      total++;
      if (o_ov !== 1'b0 || o_cnt !== 0 || o_od !== 0 || o_ir !== 1'b0) begin
        bad++;
        $display("FAIL %s[u%0d]: got ov=%b cnt=%0d data=%h ir=%b want all 0", tag, u, o_ov, o_cnt, o_od, o_ir);
      end
    end
  endtask

  // Accept one word into an empty pipe and count the extra edges until it shows at the output.
  task automatic test_latency(int u, string tag, int w);
    int n;
    step(u, tag, 1'b1, w, 1'b1, 1'b0);
    n = 0;
    sample(u);
    while (!o_ov && n < 20) begin
      step(u, tag, 1'b0, 0, 1'b1, 1'b0);
      n++;
      sample(u);
    end
    total++;
    if (n != dep[u] - 1) begin
      bad++; $display("FAIL %s[u%0d]: extra edges to out_valid got %0d want %0d", tag, u, n, dep[u] - 1);
    end
    step(u, tag, 1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic drain(int u, string tag);
    for (int i = 0; i <= dep[u]; i++) step(u, tag, 1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    set_in(0, 1'b0, 0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1 check_all_reset("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_clear();
  endtask

  task automatic test_stream();
    step(0, "stream", 1'b1, 'h11, 1'b1, 1'b0);
    step(0, "stream", 1'b1, 'h22, 1'b1, 1'b0);
    step(0, "stream", 1'b1, 'h33, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(0, "stream", 1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 5; i++) step(0, "fill", 1'b1, 'h11 * i, 1'b0, 1'b0);
    step(0, "fill", 1'b1, 'h55, 1'b1, 1'b0);
    drain(0, "fill");
  endtask

  task automatic test_bubble();
    step(0, "bubble", 1'b1, 'h11, 1'b0, 1'b0);
    step(0, "bubble", 1'b0, 0, 1'b0, 1'b0);
    step(0, "bubble", 1'b1, 'h22, 1'b0, 1'b0);
    step(0, "bubble", 1'b0, 0, 1'b0, 1'b0);
    step(0, "bubble", 1'b0, 0, 1'b0, 1'b0);
    step(0, "bubble", 1'b1, 'h33, 1'b0, 1'b0);
    step(0, "bubble", 1'b0, 0, 1'b0, 1'b0);
    step(0, "bubble", 1'b1, 'h44, 1'b0, 1'b0);
    step(0, "bubble", 1'b0, 0, 1'b0, 1'b0);
    drain(0, "bubble");
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 3; i++) step(0, "flush", 1'b1, 'h10 + i, 1'b0, 1'b0);
    step(0, "flush", 1'b1, 'hAA, 1'b0, 1'b1);
    drain(0, "flush");
  endtask

  task automatic test_async_reset();
    step(0, "arst", 1'b1, 'h01, 1'b0, 1'b0);
    step(0, "arst", 1'b1, 'h02, 1'b0, 1'b0);
    set_in(0, 1'b0, 0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1 check_all_reset("arst");
    model_clear();
    #1 rst = 1'b1;
    @(negedge clk);
    test_latency(0, "arst_resume", 'h5A);
  endtask

  task automatic test_sweep();
    int words, outs, first, last;
    for (int u = 0; u < 3; u++) begin
      test_latency(u, "sweep_lat", 'hBEEF);
      words = dep[u] + 4;
      outs = 0; first = -1; last = -1;
      for (int c = 0; c < words + dep[u] + 2; c++) begin
        step(u, "sweep", c < words, int'($urandom), 1'b1, 1'b0);
        if (o_ov) begin
          outs++;
          if (first < 0) first = c;
          last = c;
        end
      end
      total++;
      if (outs != words || last - first + 1 != words) begin
        bad++;
        $display("FAIL sweep_tput[u%0d]: got %0d words over %0d cycles want %0d over %0d",
                 u, outs, last - first + 1, words, words);
      end
    end
  endtask

  task automatic test_random();
    for (int u = 0; u < 3; u++) begin
      for (int c = 0; c < 250; c++)
        step(u, "random", ($urandom % 4) != 0, int'($urandom), ($urandom % 4) != 0, ($urandom % 20) == 0);
      drain(u, "random");
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_stream();
    test_fill_drain();
    test_bubble();
    test_flush();
    test_async_reset();
    test_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
